// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NREQ byte requesters.
// It also sequences the uart_tx clock gate: wake, launch, track busy, hold, then sleep.
module uart_tx_sched #(
   parameter int NREQ     = 4,
   parameter int WAKE_CYC = 2,
   parameter int HOLD_CYC = 16,
   parameter int BUSY_TO  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req,
   input  logic [8*NREQ-1:0]         req_data,
   output logic [NREQ-1:0]           ack,
   output logic                      tx_start,
   output logic [7:0]                tx_data,
   input  logic                      tx_busy,
   output logic                      gate_en,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic                      active,
   output logic                      err_to
);

   localparam int IW  = $clog2(NREQ);
   localparam int IW1 = IW + 1;
   localparam int WW  = $clog2(WAKE_CYC + 1);
   localparam int HW  = $clog2(HOLD_CYC + 1);
   localparam int TW  = $clog2(BUSY_TO + 1);

   localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYC - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(BUSY_TO - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAKE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE,
      HOLD
   } state_t;

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [WW-1:0]   wake_cnt;
   logic [HW-1:0]   hold_cnt;
   logic [TW-1:0]   to_cnt;

   logic            grant_vld;
   logic [IW-1:0]   grant_idx;
   logic [IW-1:0]   grant_next;
   logic [7:0]      grant_data;

   // Scan from ptr upward with wrap; the lowest offset that has req set wins.
   function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
      logic [IW:0]  res;
      logic [IW1-1:0] s;
      res = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         s = {1'b0, p} + IW1'(k);
         if (s >= IW1'(NREQ)) s = s - IW1'(NREQ);
         if (r[s[IW-1:0]]) res = {1'b1, s[IW-1:0]};
      end
      return res;
   endfunction

   always_comb begin
      {grant_vld, grant_idx} = rr_pick(req, ptr);
      grant_next = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      grant_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IW'(i)) grant_data = req_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         wake_cnt <= '0;
         hold_cnt <= '0;
         to_cnt   <= '0;
         ack      <= '0;
         tx_start <= 1'b0;
         tx_data  <= '0;
         gate_en  <= 1'b0;
         owner    <= '0;
         active   <= 1'b0;
         err_to   <= 1'b0;
      end else begin
         ack      <= '0;
         tx_start <= 1'b0;
         err_to   <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  ack      <= NREQ'(1) << grant_idx;
                  owner    <= grant_idx;
                  ptr      <= grant_next;
                  tx_data  <= grant_data;
                  gate_en  <= 1'b1;
                  active   <= 1'b1;
                  wake_cnt <= '0;
                  state    <= WAKE;
               end
            end
            WAKE: begin
               if (wake_cnt == WAKE_LAST) state <= LAUNCH;
               else wake_cnt <= wake_cnt + 1'b1;
            end
            // Never start a byte while the previous one is still shifting out.
            LAUNCH: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  to_cnt   <= '0;
                  state    <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (to_cnt == TO_LAST) begin
                  err_to   <= 1'b1;
                  hold_cnt <= '0;
                  state    <= HOLD;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  hold_cnt <= '0;
                  state    <= HOLD;
               end
            end
            // Clock is still running here, so a new grant skips the wake delay.
            HOLD: begin
               if (grant_vld) begin
                  ack     <= NREQ'(1) << grant_idx;
                  owner   <= grant_idx;
                  ptr     <= grant_next;
                  tx_data <= grant_data;
                  state   <= LAUNCH;
               end else if (hold_cnt == HOLD_LAST) begin
                  gate_en <= 1'b0;
                  active  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized traffic against an
// event-timeline reference model and a behavioural uart_tx responder.
module tb_uart_tx_sched;

   localparam int NREQ     = 4;
   localparam int WAKE_CYC = 2;
   localparam int HOLD_CYC = 16;
   localparam int BUSY_TO  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    req = '0;
   logic [31:0]   req_data = '0;
   logic [3:0]    ack;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          tx_busy = 1'b0;
   logic          gate_en;
   logic [1:0]    owner;
   logic          active;
   logic          err_to;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   // responder controls
   bit resp_rand = 0;
   bit resp_timeout = 0;
   int resp_len = 3;
   bit r_to;
   int r_d, r_len;

   uart_tx_sched #(
      .NREQ(NREQ), .WAKE_CYC(WAKE_CYC), .HOLD_CYC(HOLD_CYC), .BUSY_TO(BUSY_TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .gate_en(gate_en),
      .owner(owner), .active(active), .err_to(err_to)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // which: 0 ack, 1 tx_start, 2 err_to, 3 gate_en low, 4 busy high, 5 busy low
   task automatic wait_evt(input int which, input int lim, output int t);
      bit hit;
      hit = 0;
      for (int k = 0; k < lim && !hit; k++) begin
         step();
         case (which)
            0: hit = |ack;
            1: hit = tx_start;
            2: hit = err_to;
            3: hit = !gate_en;
            4: hit = tx_busy;
            default: hit = !tx_busy;
         endcase
      end
      check($sformatf("wait_evt%0d", which), hit, 1'b1);
      t = cyc;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   // uart_tx stand-in: busy rises d+1 cycles after tx_start, lasts len cycles, or never rises
   always begin
      @(negedge clk);
      if (rst_n && tx_start) begin
         r_to  = resp_rand ? ($urandom_range(5) == 0) : resp_timeout;
         r_d   = resp_rand ? int'($urandom_range(BUSY_TO - 2)) : 0;
         r_len = resp_rand ? int'($urandom_range(6, 1)) : resp_len;
         if (!r_to) begin
            repeat (r_d + 1) @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (r_len) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   // ---------------- reference model: expected event cycles ----------------
   localparam int P_IDLE = 0, P_PRE = 1, P_WB = 2, P_WD = 3, P_HOLD = 4;
   int ph, m_ptr, m_owner, w;
   bit m_gate;
   int e_ack_cyc, e_start_cyc, e_err_cyc, e_gon_cyc, e_goff_cyc, wb_start, hold_start;
   logic [3:0] e_ack_vec;
   logic [7:0] e_byte;

   function automatic int rr_winner(input logic [3:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic model_reset();
      ph = P_IDLE; m_ptr = 0; m_owner = 0; m_gate = 0;
      e_ack_cyc = -1; e_start_cyc = -1; e_err_cyc = -1;
      e_gon_cyc = -1; e_goff_cyc = -1; wb_start = -1; hold_start = -1;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         check("reset_outs", {ack, tx_start, tx_data, gate_en, owner, active, err_to}, '0);
         model_reset();
      end else begin
         if (cyc == e_gon_cyc) m_gate = 1;
         if (cyc == e_goff_cyc) m_gate = 0;
         check("ack", ack, (cyc == e_ack_cyc) ? e_ack_vec : 4'b0);
         check("tx_start", tx_start, cyc == e_start_cyc);
         if (cyc == e_start_cyc) begin
            check("tx_data", tx_data, e_byte);
            check("busy_at_start", tx_busy, 1'b0);
         end
         check("err_to", err_to, cyc == e_err_cyc);
         check("gate_en", gate_en, m_gate);
         check("active", active, m_gate);
         check("owner", owner, m_owner);
         case (ph)
            P_IDLE, P_HOLD: begin
               w = rr_winner(req, m_ptr);
               if (w >= 0) begin
                  e_ack_cyc = cyc + 1;
                  e_ack_vec = 4'b1 << w;
                  e_byte = req_data[8*w +: 8];
                  m_owner = w;
                  m_ptr = (w + 1) % NREQ;
                  if (ph == P_IDLE) begin
                     e_gon_cyc = cyc + 1;
                     e_start_cyc = cyc + 2 + WAKE_CYC;
                  end else begin
                     e_start_cyc = cyc + 2;
                  end
                  ph = P_PRE;
               end else if (ph == P_HOLD && cyc == hold_start + HOLD_CYC - 1) begin
                  e_goff_cyc = cyc + 1;
                  ph = P_IDLE;
               end
            end
            P_PRE: if (cyc == e_start_cyc - 1) begin
               wb_start = e_start_cyc;
               ph = P_WB;
            end
            P_WB: begin
               if (tx_busy) ph = P_WD;
               else if (cyc == wb_start + BUSY_TO - 1) begin
                  e_err_cyc = cyc + 1;
                  hold_start = cyc + 1;
                  ph = P_HOLD;
               end
            end
            default: if (!tx_busy) begin
               hold_start = cyc + 1;
               ph = P_HOLD;
            end
         endcase
      end
   end

   // ---------------- stimulus ----------------
   int t, t0, L, F;
   logic [3:0] order [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};

   initial begin
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // single request from IDLE
      req_data[23:16] = 8'hA5;
      req = 4'b0100;
      t0 = cyc;
      wait_evt(0, 20, t);
      check("t1_ack_cyc", t, t0 + 1);
      check("t1_ack", ack, 4'b0100);
      check("t1_gate", gate_en, 1'b1);
      req = '0;
      wait_evt(1, 20, t);
      check("t1_start_cyc", t, t0 + 2 + WAKE_CYC);
      check("t1_tx_data", tx_data, 8'hA5);

      // second request 5 cycles into HOLD
      wait_evt(4, 10, t);
      wait_evt(5, 20, F);
      repeat (5) step();
      check("t3_gate_held", gate_en, 1'b1);
      req_data[15:8] = 8'h3C;
      req = 4'b0010;
      wait_evt(0, 10, t);
      check("t3_ack_cyc", t, F + 6);
      req = '0;
      wait_evt(1, 10, t);
      check("t3_start_cyc", t, F + 7);
      check("t3_tx_data", tx_data, 8'h3C);

      // no further request: gate drops after the hold window
      wait_evt(4, 10, t);
      wait_evt(5, 20, F);
      wait_evt(3, 40, t);
      check("t4_gate_off_cyc", t, F + HOLD_CYC + 1);
      check("t4_active", active, 1'b0);

      // continuous requests on 0,1,3 from a fresh pointer
      do_reset();
      req_data = 32'h44_33_22_11;
      req = 4'b1011;
      for (int j = 0; j < 6; j++) begin
         wait_evt(0, 60, t);
         check($sformatf("t2_grant%0d", j), ack, order[j]);
         step();
         check($sformatf("t2_width%0d", j), ack, 4'b0);
      end
      req = '0;
      wait_evt(3, 80, t);

      // busy never rises: timeout, then the queued request is still served
      resp_timeout = 1;
      req_data = 32'h00_00_22_11;
      req = 4'b0001;
      wait_evt(0, 20, t);
      req = 4'b0010;
      wait_evt(1, 20, L);
      wait_evt(2, 20, t);
      resp_timeout = 0;
      check("t5_err_cyc", t, L + BUSY_TO);
      wait_evt(0, 10, t);
      check("t5_ack_cyc", t, L + BUSY_TO + 1);
      check("t5_ack", ack, 4'b0010);
      req = '0;
      wait_evt(1, 10, t);
      check("t5_tx_data", tx_data, 8'h22);
      wait_evt(3, 60, t);

      // reset while uart_tx is busy
      resp_len = 8;
      req_data = 32'hDE_00_00_00;
      req = 4'b1000;
      wait_evt(0, 20, t);
      req = '0;
      wait_evt(4, 20, t);
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      check("t6_async_zero", {ack, tx_start, tx_data, gate_en, owner, active, err_to}, '0);
      wait_evt(5, 20, t);
      step();
      resp_len = 3;
      rst_n = 1'b1;
      req_data = 32'h78_56_34_12;
      req = 4'b1111;
      wait_evt(0, 10, t);
      check("t6_first_grant", ack, 4'b0001);
      req = '0;
      wait_evt(3, 80, t);

      // randomized traffic with quiet windows so the gate goes to sleep
      resp_rand = 1;
      for (int k = 0; k < 3000; k++) begin
         step();
         for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
               if ($urandom_range(3) == 0) req_data[8*i +: 8] = 8'($urandom);
               else req[i] = 1'b0;
            end else if (!req[i] && (k % 400) < 340 && $urandom_range(59) == 0) begin
               req_data[8*i +: 8] = 8'($urandom);
               req[i] = 1'b1;
            end
         end
      end
      req = '0;
      wait_evt(3, 200, t);
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
